// File: rtl/reaction_timer_pkg.sv
// Shared types and default sizing for the reaction timer.
package reaction_timer_pkg;

  localparam int DEF_WIDTH      = 24;
  localparam int DEF_TIMEOUT_MS = 2000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DONE  = 3'd2,
    TOUT  = 3'd3,
    FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/reaction_timer_rise_detect.sv
// Rising-edge detector for the go level; needs to see the input low at least
// once after reset before it will report an edge.
module rise_detect (
  input  logic clk_1ms,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic armed_q;

  // armed_q keeps a level held high through reset from looking like a new edge
  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= in;
      armed_q <= armed_q | ~in;
    end
  end

  assign pulse = in & ~prev_q & armed_q;

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction timer: counts ms from a go edge until stop, tracks the best time,
// and flags timeouts and false starts. All outputs are registered.
module reaction_timer_fsm
  import reaction_timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS
) (
  input  logic             clk_1ms,
  input  logic             reset_n,
  input  logic             go,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] time_elapsed,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] best_time,
  output logic             best_valid,
  output logic             timeout,
  output logic             false_start,
  output logic             busy
);

  if (TIMEOUT_MS < 2 ||
      longint'(TIMEOUT_MS) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_timeout
    $error("reaction_timer_fsm: TIMEOUT_MS out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] T_LAST = WIDTH'(TIMEOUT_MS - 1);
  localparam logic [WIDTH-1:0] T_FULL = WIDTH'(TIMEOUT_MS);

  state_e           state_q;
  logic [WIDTH-1:0] te_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] best_q;
  logic             result_valid_q;
  logic             best_valid_q;
  logic             timeout_q;
  logic             false_start_q;
  logic             busy_q;

  logic             go_rise;
  logic [WIDTH-1:0] te_d;
  logic             new_best_d;

  rise_detect u_go_rise (
    .clk_1ms (clk_1ms),
    .reset_n (reset_n),
    .in      (go),
    .pulse   (go_rise)
  );

  assign te_d       = te_q + WIDTH'(1);
  assign new_best_d = !best_valid_q || (te_q < best_q);

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      te_q           <= '0;
      result_q       <= '0;
      best_q         <= '0;
      result_valid_q <= 1'b0;
      best_valid_q   <= 1'b0;
      timeout_q      <= 1'b0;
      false_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      te_q           <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      false_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_rise) begin
            if (stop) begin
              state_q       <= FAULT;
              false_start_q <= 1'b1;
            end else begin
              state_q <= RUN;
              te_q    <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // stop is checked first so a press on the last count still scores
          if (stop) begin
            state_q        <= DONE;
            result_q       <= te_q;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            best_valid_q   <= 1'b1;
            if (new_best_d) best_q <= te_q;
          end else if (te_q == T_LAST) begin
            state_q   <= TOUT;
            te_q      <= T_FULL;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            te_q <= te_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign time_elapsed = te_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign best_time    = best_q;
  assign best_valid   = best_valid_q;
  assign timeout      = timeout_q;
  assign false_start  = false_start_q;
  assign busy         = busy_q;

endmodule
